// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter: picorv32 (m0) and UART DMA (m1).
// Optional no-ack watchdog with abort: define WB_ARB_TIMEOUT_EN.
module wb_master_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int OUT_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            in_rst,
  input  logic            i_m0_cyc,
  input  logic            i_m0_stb,
  input  logic            i_m0_we,
  input  logic [AW-1:0]   i_m0_addr,
  input  logic [DW-1:0]   i_m0_data,
  input  logic [DW/8-1:0] i_m0_sel,
  output logic            o_m0_ack,
  output logic            o_m0_stall,
  output logic            o_m0_err,
  output logic [DW-1:0]   o_m0_data,
  input  logic            i_m1_cyc,
  input  logic            i_m1_stb,
  input  logic            i_m1_we,
  input  logic [AW-1:0]   i_m1_addr,
  input  logic [DW-1:0]   i_m1_data,
  input  logic [DW/8-1:0] i_m1_sel,
  output logic            o_m1_ack,
  output logic            o_m1_stall,
  output logic            o_m1_err,
  output logic [DW-1:0]   o_m1_data,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data,
  output logic [1:0]      o_grant
);

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, OWN0, OWN1, GAP, ABORT} state_t;
`else
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;
`endif

  state_t           state;
  logic [1:0]       grant;
  logic             last_owner;
  logic [OUT_W-1:0] outstanding;

  logic            own0, own1, owning, sel1;
  logic            sat, live, ack_ok, err_ok;
  logic            accept, timeout_hit;
  logic            m_cyc, m_stb, m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  logic [DW/8-1:0] m_sel;

  assign o_grant = grant;
  assign own0    = (state == OWN0);
  assign own1    = (state == OWN1);
  assign owning  = own0 | own1;
  assign sel1    = grant[1];

  assign m_cyc  = sel1 ? i_m1_cyc  : i_m0_cyc;
  assign m_stb  = sel1 ? i_m1_stb  : i_m0_stb;
  assign m_we   = sel1 ? i_m1_we   : i_m0_we;
  assign m_addr = sel1 ? i_m1_addr : i_m0_addr;
  assign m_data = sel1 ? i_m1_data : i_m0_data;
  assign m_sel  = sel1 ? i_m1_sel  : i_m0_sel;

  // Responses only count while the owner has something in flight.
  assign sat    = &outstanding;
  assign live   = owning && (outstanding != '0);
  assign ack_ok = live & i_wb_ack;
  assign err_ok = live & i_wb_err;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  assign timeout_hit = live && !i_wb_ack && !i_wb_err &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge in_rst) begin
    if (!in_rst)
      to_cnt <= '0;
    else if (live && m_cyc && !i_wb_ack && !i_wb_err && !timeout_hit)
      to_cnt <= to_cnt + 1'b1;
    else
      to_cnt <= '0;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign o_wb_cyc  = owning & m_cyc & ~timeout_hit;
  assign o_wb_stb  = o_wb_cyc & m_stb & ~sat;
  assign o_wb_we   = owning & m_we;
  assign o_wb_addr = owning ? m_addr : '0;
  assign o_wb_data = owning ? m_data : '0;
  assign o_wb_sel  = owning ? m_sel  : '0;
  assign accept    = o_wb_stb & ~i_wb_stall;

  assign o_m0_ack   = own0 & ack_ok;
  assign o_m0_err   = own0 & (err_ok | timeout_hit);
  assign o_m0_stall = ~own0 | i_wb_stall | sat | timeout_hit;
  assign o_m0_data  = own0 ? i_wb_data : '0;

  assign o_m1_ack   = own1 & ack_ok;
  assign o_m1_err   = own1 & (err_ok | timeout_hit);
  assign o_m1_stall = ~own1 | i_wb_stall | sat | timeout_hit;
  assign o_m1_data  = own1 ? i_wb_data : '0;

  always_ff @(posedge i_clk or negedge in_rst) begin
    if (!in_rst) begin
      state       <= IDLE;
      grant       <= 2'b00;
      last_owner  <= 1'b1;
      outstanding <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_m0_cyc && (!i_m1_cyc || last_owner)) begin
            state      <= OWN0;
            grant      <= 2'b01;
            last_owner <= 1'b0;
          end else if (i_m1_cyc) begin
            state      <= OWN1;
            grant      <= 2'b10;
            last_owner <= 1'b1;
          end
        end
        OWN0, OWN1: begin
`ifdef WB_ARB_TIMEOUT_EN
          if (timeout_hit) begin
            state       <= ABORT;
            outstanding <= '0;
          end else
`endif
          if (!m_cyc) begin
            state       <= GAP;
            grant       <= 2'b00;
            outstanding <= '0;
          end else if (accept && !(ack_ok || err_ok)) begin
            outstanding <= outstanding + 1'b1;
          end else if (!accept && (ack_ok || err_ok)) begin
            outstanding <= outstanding - 1'b1;
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        ABORT: begin
          if (!m_cyc) begin
            state <= GAP;
            grant <= 2'b00;
          end
        end
`endif
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: vector table plus corner sequences.
// Timeout sequence runs only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_master_arbiter;

  logic        i_clk = 1'b0;
  logic        in_rst;
  logic        i_m0_cyc, i_m0_stb, i_m0_we;
  logic [31:0] i_m0_addr, i_m0_data;
  logic [3:0]  i_m0_sel;
  logic        o_m0_ack, o_m0_stall, o_m0_err;
  logic [31:0] o_m0_data;
  logic        i_m1_cyc, i_m1_stb, i_m1_we;
  logic [31:0] i_m1_addr, i_m1_data;
  logic [3:0]  i_m1_sel;
  logic        o_m1_ack, o_m1_stall, o_m1_err;
  logic [31:0] o_m1_data;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack, i_wb_stall, i_wb_err;
  logic [31:0] i_wb_data;
  logic [1:0]  o_grant;

  always #5 i_clk = ~i_clk;

  wb_master_arbiter #(
    .AW(32), .DW(32), .OUT_W(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk(i_clk), .in_rst(in_rst),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
    .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data), .i_m0_sel(i_m0_sel),
    .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall), .o_m0_err(o_m0_err),
    .o_m0_data(o_m0_data),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
    .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data), .i_m1_sel(i_m1_sel),
    .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall), .o_m1_err(o_m1_err),
    .o_m1_data(o_m1_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data), .o_grant(o_grant)
  );

  typedef struct packed {
    logic        m0c, m0s, m1c, m1s, ack;
    logic [1:0]  g;
    logic        cyc, stb, a0, a1, s0, s1;
    logic [31:0] addr;
  } vec_t;

  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h0000_8000;

  vec_t vecs[30];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic m0c, m0s, m1c, m1s, ack, stall);
    @(negedge i_clk);
    i_m0_cyc   = m0c;
    i_m0_stb   = m0s;
    i_m1_cyc   = m1c;
    i_m1_stb   = m1s;
    i_wb_ack   = ack;
    i_wb_stall = stall;
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    in_rst   = 1'b0;
    i_m0_cyc = 0; i_m0_stb = 0; i_m1_cyc = 0; i_m1_stb = 0;
    i_wb_ack = 0; i_wb_stall = 0; i_wb_err = 0;
    repeat (2) @(negedge i_clk);
    in_rst = 1'b1;
  endtask

  initial begin
    int acc;
    int bad;
    logic [47:0] act;

    i_m0_we = 1'b0; i_m0_addr = A0; i_m0_data = 32'h0; i_m0_sel = 4'hF;
    i_m1_we = 1'b1; i_m1_addr = A1; i_m1_data = 32'h1234_5678;
    i_m1_sel = 4'hF;
    i_wb_data = 32'hDEAD_BEEF;

    // Six single transfers, both masters contending: five cycles per round.
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 5; p++) begin
        vec_t v;
        logic oc, os, want0;
        oc    = (p <= 2);
        os    = (p <= 1);
        want0 = ((r + 1) / 2) < 3;
        v = '0;
        if (r % 2 == 0) begin
          v.m0c = oc; v.m0s = os; v.m1c = 1'b1; v.m1s = 1'b1;
        end else begin
          v.m1c = oc; v.m1s = os; v.m0c = want0; v.m0s = want0;
        end
        v.ack = (p == 2);
        v.s0 = 1'b1;
        v.s1 = 1'b1;
        if (p >= 1 && p <= 3) begin
          v.g    = (r % 2 == 0) ? 2'b01 : 2'b10;
          v.cyc  = (p <= 2);
          v.stb  = (p == 1);
          v.addr = (r % 2 == 0) ? A0 : A1;
          if (r % 2 == 0) begin
            v.s0 = 1'b0; v.a0 = (p == 2);
          end else begin
            v.s1 = 1'b0; v.a1 = (p == 2);
          end
        end
        vecs[r*5+p] = v;
      end
    end

    do_reset();
    #1;
    check("rst_grant", 64'(o_grant), 64'(2'b00));
    check("rst_bus", 64'({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel}), 64'h0);
    check("rst_addr", 64'({o_wb_addr, o_wb_data}), 64'h0);
    check("rst_resp",
          64'({o_m0_ack, o_m0_err, o_m1_ack, o_m1_err,
               o_m0_stall, o_m1_stall}), 64'(6'b000011));
    check("rst_rdata", 64'({o_m0_data, o_m1_data}), 64'h0);

    for (int i = 0; i < 30; i++) begin
      step(vecs[i].m0c, vecs[i].m0s, vecs[i].m1c, vecs[i].m1s,
           vecs[i].ack, 1'b0);
      act = {o_grant, o_wb_cyc, o_wb_stb, o_m0_ack, o_m1_ack,
             o_m0_stall, o_m1_stall, o_wb_addr};
      check($sformatf("rr_vec%0d", i), 64'(act),
            64'({vecs[i].g, vecs[i].cyc, vecs[i].stb, vecs[i].a0,
                 vecs[i].a1, vecs[i].s0, vecs[i].s1, vecs[i].addr}));
    end

    // Single m0 read
    do_reset();
    step(1, 1, 0, 0, 0, 0);
    check("rd_idle_grant", 64'({o_grant, o_m0_stall}), 64'(3'b001));
    step(1, 1, 0, 0, 0, 0);
    check("rd_grant", 64'({o_grant, o_wb_stb, o_wb_addr}),
          64'({2'b01, 1'b1, A0}));
    step(1, 0, 0, 0, 1, 0);
    check("rd_ack", 64'({o_m0_ack, o_m0_data}), 64'({1'b1, 32'hDEAD_BEEF}));
    check("rd_m1_idle", 64'({o_m1_stall, o_m1_ack, o_m1_data}),
          64'({1'b1, 1'b0, 32'h0}));
    step(0, 0, 0, 0, 0, 0);

    // m1 write held off by slave stall
    do_reset();
    acc = 0;
    step(0, 0, 1, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 1, 0, 1);
      if (o_wb_stb && !i_wb_stall) acc++;
      check($sformatf("wr_stall%0d", k), 64'({o_m1_stall, o_wb_stb}),
            64'(2'b11));
    end
    step(0, 0, 1, 1, 0, 0);
    if (o_wb_stb && !i_wb_stall) acc++;
    check("wr_accept",
          64'({o_m1_stall, o_wb_we, o_wb_sel, o_wb_addr[15:0], o_wb_data}),
          64'({1'b0, 1'b1, 4'hF, 16'h8000, 32'h1234_5678}));
    step(0, 0, 1, 0, 1, 0);
    check("wr_ack", 64'(o_m1_ack), 64'(1'b1));
    check("wr_one_beat", 64'(acc), 64'(1));
    step(0, 0, 1, 0, 1, 0);
    check("wr_stray_ack", 64'(o_m1_ack), 64'(1'b0));
    check("wr_outstanding", 64'(dut.outstanding), 64'(0));
    step(0, 0, 0, 0, 0, 0);

    // Outstanding-counter saturation, then reset mid-transfer
    do_reset();
    bad = 0;
    step(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 15; k++) begin
      step(1, 1, 0, 0, 0, 0);
      if (o_m0_stall || !o_wb_stb) bad++;
    end
    check("sat_fill", 64'(bad), 64'(0));
    step(1, 1, 0, 0, 0, 0);
    check("sat_stall", 64'({o_m0_stall, o_wb_stb}), 64'(2'b10));
    step(1, 1, 0, 0, 1, 0);
    check("sat_ack", 64'({o_m0_ack, o_m0_stall}), 64'(2'b11));
    step(1, 1, 0, 0, 0, 0);
    check("sat_release", 64'({o_m0_stall, o_wb_stb}), 64'(2'b01));
    @(negedge i_clk);
    i_wb_ack = 1'b1;
    in_rst   = 1'b0;
    #1;
    check("rst_mid", 64'({o_m0_ack, o_grant, o_wb_cyc, o_m0_stall}),
          64'(5'b00001));

    // Owner leaves with two in flight; late acks must vanish
    do_reset();
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    check("late_drop_cyc", 64'(o_wb_cyc), 64'(1'b0));
    step(0, 0, 1, 1, 1, 0);
    check("late_gap", 64'({o_m0_ack, o_m1_ack, o_grant, o_wb_cyc}),
          64'(5'b0));
    step(0, 0, 1, 1, 1, 0);
    check("late_idle", 64'({o_m0_ack, o_m1_ack, o_grant, o_wb_cyc}),
          64'(5'b0));
    step(0, 0, 1, 1, 0, 0);
    check("late_m1_grant", 64'({o_grant, o_wb_stb, o_m1_ack}),
          64'(4'b1010));
    step(0, 0, 1, 0, 1, 0);
    check("late_m1_ack", 64'({o_m1_ack, o_m0_ack}), 64'(2'b10));
    step(0, 0, 0, 0, 0, 0);

`ifdef WB_ARB_TIMEOUT_EN
    do_reset();
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 1, 1, 0, 0);
      check($sformatf("to_wait%0d", k), 64'({o_m0_err, o_wb_cyc}),
            64'({k == 8, k != 8}));
    end
    step(1, 0, 1, 1, 0, 0);
    check("to_abort",
          64'({o_m0_err, o_wb_cyc, o_m0_stall, o_m1_stall}), 64'(4'b0011));
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    check("to_gap", 64'(o_grant), 64'(2'b00));
    step(0, 0, 1, 1, 0, 0);
    check("to_idle", 64'(o_grant), 64'(2'b00));
    step(0, 0, 1, 1, 0, 0);
    check("to_m1_grant", 64'({o_grant, o_wb_cyc}), 64'(3'b101));
    step(0, 0, 0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
